// File: rtl/subtractor_512bit_seq_if.sv
// subtractor_512bit_seq_if: valid/ready operand and result bundle for subtractor_512bit_seq.
// The ovf signal exists only when SUB_OVERFLOW_EN is defined.
interface subtractor_512bit_seq_if #(
  parameter int DATA_W = 512
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din_one;
  logic [DATA_W-1:0] din_two;
  logic              bin;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] diff;
  logic              bout;
`ifdef SUB_OVERFLOW_EN
  logic              ovf;
  modport master (output in_valid, din_one, din_two, bin, out_ready,
                  input in_ready, out_valid, diff, bout, ovf);
  modport slave (input in_valid, din_one, din_two, bin, out_ready,
                 output in_ready, out_valid, diff, bout, ovf);
`else
  modport master (output in_valid, din_one, din_two, bin, out_ready,
                  input in_ready, out_valid, diff, bout);
  modport slave (input in_valid, din_one, din_two, bin, out_ready,
                 output in_ready, out_valid, diff, bout);
`endif
endinterface

// File: rtl/subtractor_512bit_seq.sv
// subtractor_512bit_seq: multi-cycle diff = din_one - din_two - bin, one CHUNK_W slice per clock.
// Defining SUB_OVERFLOW_EN adds the registered signed-overflow flag ovf.
module subtractor_512bit_seq #(
  parameter int DATA_W  = 512,
  parameter int CHUNK_W = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  subtractor_512bit_seq_if.slave bus
);
  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  if (DATA_W % CHUNK_W != 0) begin : g_bad_chunk
    $error("DATA_W must be an integer multiple of CHUNK_W");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            r_state;
  logic [DATA_W-1:0] r_a, r_b, r_diff;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_borrow, r_bout, r_in_ready, r_out_valid;
  logic [CHUNK_W-1:0] w_a_sl, w_b_sl;
  logic [CHUNK_W:0]   w_sub;
  logic               w_last;
  assign w_a_sl = r_a[r_cnt*CHUNK_W +: CHUNK_W];
  assign w_b_sl = r_b[r_cnt*CHUNK_W +: CHUNK_W];
  // the extra top bit of the widened difference is the slice's borrow out
  assign w_sub  = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{CHUNK_W{1'b0}}, r_borrow};
  assign w_last = (r_cnt == CNT_W'(NCHUNK - 1));
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
`ifdef SUB_OVERFLOW_EN
  logic r_ovf;
  assign bus.ovf = r_ovf;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_cnt       <= '0;
      r_borrow    <= 1'b0;
      r_bout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_a        <= bus.din_one;
          r_b        <= bus.din_two;
          r_borrow   <= bus.bin;
          r_cnt      <= '0;
          r_in_ready <= 1'b0;
          r_state    <= CALC;
        end
        CALC: begin
          r_diff[r_cnt*CHUNK_W +: CHUNK_W] <= w_sub[CHUNK_W-1:0];
          r_borrow <= w_sub[CHUNK_W];
          r_cnt    <= w_last ? r_cnt : r_cnt + 1'b1;
          if (w_last) begin
            r_bout      <= w_sub[CHUNK_W];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
`ifdef SUB_OVERFLOW_EN
            // signed overflow: operand signs differ and result sign departs from the minuend's
            r_ovf <= (r_a[DATA_W-1] ^ r_b[DATA_W-1]) & (w_sub[CHUNK_W-1] ^ r_a[DATA_W-1]);
`endif
          end
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
